// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by seq_alu and seq_muldiv.
package alu_pkg;

   localparam int ALU_CTRL_W = 4;

   typedef enum logic [ALU_CTRL_W-1:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_SLT   = 4'b0101,
      OP_SLTU  = 4'b0110,
      OP_SLL   = 4'b0111,
      OP_SRL   = 4'b1000,
      OP_SRA   = 4'b1001,
      OP_PASSB = 4'b1010,
      OP_MUL   = 4'b1011,
      OP_MULHU = 4'b1100,
      OP_DIVU  = 4'b1101,
      OP_REMU  = 4'b1110,
      OP_RSVD  = 4'b1111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } alu_state_t;

   function automatic logic is_muldiv(input alu_op_t op);
      return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative shift-add multiplier and restoring divider.
// One step per cycle; lo/hi show the value after the current step.
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic                  is_div,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] lo,
   output logic [DATA_WIDTH-1:0] hi
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic [CNT_W-1:0]      cnt;
   logic                  div_q;
   logic [DATA_WIDTH-1:0] lo_q;
   logic [DATA_WIDTH-1:0] hi_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH:0]   shl;
   logic [DATA_WIDTH:0]   diff;

   assign done = busy && (cnt == CNT_W'(DATA_WIDTH - 1));

   // hi:lo is the product accumulator, or remainder:quotient for divide
   always_comb begin
      sum  = {1'b0, hi_q} + {1'b0, b_q};
      shl  = {hi_q, lo_q[DATA_WIDTH-1]};
      diff = shl - {1'b0, b_q};
      if (div_q) begin
         hi = diff[DATA_WIDTH] ? shl[DATA_WIDTH-1:0]
                               : diff[DATA_WIDTH-1:0];
         lo = {lo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
      end else if (lo_q[0]) begin
         hi = sum[DATA_WIDTH:1];
         lo = {sum[0], lo_q[DATA_WIDTH-1:1]};
      end else begin
         hi = {1'b0, hi_q[DATA_WIDTH-1:1]};
         lo = {hi_q[0], lo_q[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         cnt   <= '0;
         div_q <= 1'b0;
         lo_q  <= '0;
         hi_q  <= '0;
         b_q   <= '0;
      end else if (go && !busy) begin
         busy  <= 1'b1;
         cnt   <= '0;
         div_q <= is_div;
         lo_q  <= a;
         hi_q  <= '0;
         b_q   <= b;
      end else if (busy) begin
         lo_q <= lo;
         hi_q <= hi;
         cnt  <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU, registered outputs, start/done handshake.
// Define SEQ_ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU path.
module seq_alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ALU_CTRL_W-1:0] ALUctrl,
   input  logic [DATA_WIDTH-1:0] ALUop1,
   input  logic [DATA_WIDTH-1:0] ALUop2,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   alu_op_t               op;
   logic                  accept;
   logic [SHAMT_W-1:0]    shamt;
   logic [DATA_WIDTH-1:0] alu_res;

   assign op     = alu_op_t'(ALUctrl);
   assign accept = start && !busy;
   assign shamt  = ALUop2[SHAMT_W-1:0];

   always_comb begin
      alu_res = '0;
      unique case (op)
         OP_ADD:   alu_res = ALUop1 + ALUop2;
         OP_SUB:   alu_res = ALUop1 - ALUop2;
         OP_AND:   alu_res = ALUop1 & ALUop2;
         OP_OR:    alu_res = ALUop1 | ALUop2;
         OP_XOR:   alu_res = ALUop1 ^ ALUop2;
         OP_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}},
                              $signed(ALUop1) < $signed(ALUop2)};
         OP_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ALUop1 < ALUop2};
         OP_SLL:   alu_res = ALUop1 << shamt;
         OP_SRL:   alu_res = ALUop1 >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(ALUop1) >>> shamt);
         OP_PASSB: alu_res = ALUop2;
`ifdef SEQ_ALU_MULDIV_EN
         // only reached for a zero divisor; nonzero goes to the core
         OP_DIVU:  alu_res = '1;
         OP_REMU:  alu_res = ALUop1;
`endif
         default:  alu_res = '0;
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN

   alu_state_t            state;
   logic                  md_go;
   logic                  md_div;
   logic                  md_busy;
   logic                  md_done;
   logic                  sel_hi;
   logic [DATA_WIDTH-1:0] md_lo;
   logic [DATA_WIDTH-1:0] md_hi;

   assign md_div = (op == OP_DIVU) || (op == OP_REMU);
   assign md_go  = accept && is_muldiv(op)
                   && !(md_div && ALUop2 == '0);

   seq_muldiv #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .go     (md_go),
      .is_div (md_div),
      .a      (ALUop1),
      .b      (ALUop2),
      .busy   (md_busy),
      .done   (md_done),
      .lo     (md_lo),
      .hi     (md_hi)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b1;
         sel_hi    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (md_go) begin
                  state  <= md_div ? DIV : MUL;
                  busy   <= 1'b1;
                  sel_hi <= (op == OP_MULHU) || (op == OP_REMU);
               end else if (accept) begin
                  ALUResult <= alu_res;
                  Zero      <= (alu_res == '0);
                  done      <= 1'b1;
               end
            end
            MUL, DIV: begin
               if (md_done) begin
                  ALUResult <= sel_hi ? md_hi : md_lo;
                  Zero      <= ((sel_hi ? md_hi : md_lo) == '0);
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (!md_busy) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`else

   assign busy = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         done      <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b1;
      end else begin
         done <= accept;
         if (accept) begin
            ALUResult <= alu_res;
            Zero      <= (alu_res == '0);
         end
      end
   end

`endif

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised successor to the single-cycle datapath ALU. Adds logic, compare and shift ops, plus iterative unsigned multiply and divide (RV32M subset) behind a start/done handshake. Sits in the execute stage. Control stalls issue while busy is high. All outputs are registered.

Parameters:
DATA_WIDTH, 32, operand/result width; power of two, >= 8
SHAMT_W, $clog2(DATA_WIDTH), shift-amount width, derived (localparam)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; accepted only when busy=0
ALUctrl  input  4  operation code, sampled on accept
ALUop1  input  DATA_WIDTH  operand A, sampled on accept
ALUop2  input  DATA_WIDTH  operand B, sampled on accept
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse, ALUResult/Zero valid
ALUResult  output  DATA_WIDTH  result, held until next completion
Zero  output  1  ALUResult == 0, registered with ALUResult

Behaviour:
- Reset (sync, active-high): busy=0, done=0, ALUResult=0, Zero=1, FSM=IDLE. Reset mid-operation aborts the op and discards all partial state.
- Accept condition: start=1 && busy=0 at a rising edge. Inputs are latched at that edge; later input changes are ignored.
- start while busy=1 is ignored and is not queued.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed, result 1/0), 0110 SLTU (unsigned)
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount = ALUop2[SHAMT_W-1:0]
  - 1010 PASSB (result = ALUop2)
  - 1011 MUL (low word), 1100 MULHU (high word, unsigned)
  - 1101 DIVU, 1110 REMU
  - 1111 reserved: result 0
- Arithmetic is modulo 2^DATA_WIDTH with no overflow flag. SUB is op1 - op2.
- Single-cycle ops (0000-1010, 1111): result registered at the accept edge; done=1 in the following cycle; busy stays 0.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accept of 1011/1100.
  - IDLE -> DIV on accept of 1101/1110.
  - MUL/DIV -> IDLE when the iteration counter reaches DATA_WIDTH-1.
- Multi-cycle ops:
  - busy=1 for exactly DATA_WIDTH cycles after the accept edge.
  - One shift-add or restoring-subtract step per cycle.
  - At the final edge the result is registered and busy falls; done=1 in the next cycle. Latency is DATA_WIDTH+1 cycles from accept to done.
- Back-to-back: start may be accepted in the done cycle, since busy=0 there.
- Divide by zero (op2=0) completes in single-cycle latency without entering DIV:
  - DIVU result = all ones.
  - REMU result = ALUop1.
- done is high for exactly one cycle per accepted op. ALUResult and Zero do not change except on completion or reset.

Optional Feature:
Macro SEQ_ALU_MULDIV_EN.
- Defined: MUL/DIV states and the iterative core are built; opcodes 1011-1110 behave as above.
- Undefined: no MUL/DIV states or core logic. Opcodes 1011-1110 behave as reserved (result 0, Zero=1, single-cycle latency, busy never asserts).

Decomposition:
- Package alu_pkg:
  - enum alu_op_t (4-bit opcode values above)
  - enum alu_state_t (IDLE, MUL, DIV)
  - constant ALU_CTRL_W=4
- Sub-module seq_muldiv: iterative shift-add multiplier and restoring divider.
  - Parameter: DATA_WIDTH.
  - Ports: clk, rst, go, is_div, a, b, busy, done, lo, hi; lo/hi carry quotient/remainder for divide.
  - Only instantiated under SEQ_ALU_MULDIV_EN.
- seq_alu owns the opcode decode, the single-cycle datapath and the output registers.

Test Plan:
1. ADD 5+7: accept at cycle 0 -> done=1 in cycle 1, ALUResult=12, Zero=0, busy never 1. Then SUB 9-9 -> ALUResult=0, Zero=1.
2. SRA 0x8000_0000 by 4 -> 0xF800_0000. SLT 0xFFFF_FFFF<1 -> 1. SLTU of the same operands -> 0.
3. MUL 0xFFFF_FFFF*2 -> busy for 32 cycles, done at cycle 33, ALUResult=0xFFFF_FFFE. MULHU on the same operands -> 1.
4. DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFF_FFFF with done at cycle 1. REMU 5/0 -> 5.
5. Start a MUL, then pulse start with ADD at cycle 10 and change the operands -> ADD ignored, MUL result unchanged. ADD issued in the done cycle is accepted and completes one cycle later.
6. rst at cycle 15 of a DIVU -> next cycle busy=0, done=0, ALUResult=0, Zero=1. No done pulse follows. A new op after reset completes normally.
